bullet_hit_detector: RTL and testbench
======================================

Name: bullet_hit_detector

Overview:
Receiving end of the time-multiplexed bullet-position bus. The upstream mux drives one bullet slot's (x, y) per clock in fixed round-robin order 0..7. This block tracks the slot index locally in lockstep and tests each sample against the current duck bounding box. Detected hits are held per slot and reported one at a time over a valid/ready handshake to the score/duck-kill logic, with a saturating hit counter.

Parameters:
DUCK_W, 11'd64, duck hitbox width in pixels
DUCK_H, 10'd48, duck hitbox height in pixels
FIRST_SLOT, 3'd1, slot index tagged on the first accepted sample after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
bullet_y  in  10 signed  muxed bullet Y, one slot per cycle
bullet_x  in  11 signed  muxed bullet X, one slot per cycle
duck_x  in  11 signed  hitbox left edge
duck_y  in  10 signed  hitbox top edge
duck_alive  in  1  hits counted only while high
hit_valid  out  1  a hit report is presented
hit_slot  out  3  bullet slot of presented hit
hit_ready  in  1  consumer accepts report
hit_pending  out  8  per-slot pending-hit mask
frame_done  out  1  one-cycle pulse after slot 7 sample processed
hit_count  out  8  total accepted hits, saturating at 255

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset: hit_valid=0, hit_slot=0, hit_pending=0, frame_done=0, hit_count=0, warm-up flag=1, slot counter=FIRST_SLOT, FSM=IDLE.
- Reset asserted mid-operation clears everything on that edge. An in-flight report is dropped; hit_valid falls at that edge.
- Warm-up: the first edge with reset low discards the bus sample and clears the warm-up flag. The slot counter does not advance on this edge.
- Sampling: every later edge processes the bus as slot = counter, then counter += 1 (wraps 7 -> 0).
- frame_done=1 for exactly the cycle after the edge that processed slot 7.
- Inactive bullet: bullet_x<0 or bullet_y<0. Such a sample never hits.
- Hit test: signed, operands sign-extended to 12 bits. A sample hits when all of the following hold:
  - duck_x <= bullet_x < duck_x+DUCK_W
  - duck_y <= bullet_y < duck_y+DUCK_H
  - duck_alive=1
  - the bullet is active
- A hit sets hit_pending[slot] at the same edge (latency 1 from sample edge to mask).
- Report FSM:
  - IDLE: if hit_pending!=0, next edge loads hit_slot = lowest set index, hit_valid=1, goto REPORT.
  - REPORT: hit_valid and hit_slot are held stable until hit_ready=1. On the edge with hit_valid&&hit_ready: clear hit_pending[hit_slot], hit_valid=0, hit_count+=1 (hold at 255), goto IDLE.
  - Minimum one IDLE cycle between reports, so back-to-back reports have a 2-cycle spacing.
- Simultaneous set and clear of the same slot on the ack edge: set wins; the bit stays 1 and is reported again later.
- Sets of other slots during REPORT accumulate normally.
- A pending bit for a slot that hits again stays 1; there is no double counting.
- duck_alive falling does not clear pending hits.

Optional Feature:
HIT_REARM_EN.
- Defined: per-slot armed bit, reset to 1.
  - A hit requires armed=1 and clears armed[slot].
  - armed[slot] re-sets only when that slot is sampled as non-hitting (outside box, inactive, or duck_alive=0).
  - A bullet resting in the box yields exactly one hit.
  - The simultaneous set/clear case cannot occur for an unarmed slot.
- Undefined: no armed state. A bullet remaining in the box re-sets pending every scan after each ack.

Test Plan:
1. Reset then warm-up: hold reset 3 cycles, release, drive a constant in-box point with duck_alive=1 → first processed slot is 1. hit_pending=8'h02 after second edge. hit_valid rises the next edge with hit_slot=1.
2. Box edges: duck_x=100, duck_y=50, samples (100,50) hit, (163,97) hit, (164,97) miss, (99,50) miss, (120,-1) miss → hit_pending matches per slot. No hit when duck_alive=0.
3. Priority/backpressure: slots 2, 5, 6 hit in one frame, hit_ready=0 for 10 cycles → hit_slot=2 held stable. Then hit_ready=1 → reports 2, 5, 6 in order. hit_count=3.
4. Saturation: force 260 accepted hits → hit_count stops at 255.
5. Reset mid-REPORT: hit_valid=1, assert reset → same edge hit_valid=0, hit_pending=0, hit_count=0. After release, warm-up is repeated.
6. Persistent bullet in box for 4 frames with hit_ready=1: with HIT_REARM_EN → hit_count=1. Without it → hit_count=4. frame_done pulses 4 times, 8 cycles apart.

Source files
------------

// File: rtl/bullet_hit_detector.sv
// bullet_hit_detector
// Receiving end of the time-multiplexed bullet-position bus. Tracks the slot
// index in lockstep with the upstream mux and tests each (x, y) sample
// against the duck hitbox. Hits are latched per slot and reported one at a
// time over a valid/ready handshake. A saturating counter tallies accepted
// reports.
// Optional feature macro: HIT_REARM_EN. When it is defined, each slot must
// leave the box (or go inactive, or see duck_alive low) before it can score
// again.
module bullet_hit_detector #(
   parameter logic [10:0] DUCK_W     = 11'd64,
   parameter logic [9:0]  DUCK_H     = 10'd48,
   parameter logic [2:0]  FIRST_SLOT = 3'd1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [9:0]  bullet_y,
   input  logic signed [10:0] bullet_x,
   input  logic signed [10:0] duck_x,
   input  logic signed [9:0]  duck_y,
   input  logic               duck_alive,
   output logic               hit_valid,
   output logic [2:0]         hit_slot,
   input  logic               hit_ready,
   output logic [7:0]         hit_pending,
   output logic               frame_done,
   output logic [7:0]         hit_count
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REPORT = 1'b1
   } state_t;

   state_t      r_state;
   logic        r_warm;
   logic [2:0]  r_slot_cnt;
   logic        r_frame_done;
   logic [7:0]  r_pending;
   logic        r_hit_valid;
   logic [2:0]  r_hit_slot;
   logic [7:0]  r_hit_count;

   // All comparisons happen at 12 bits so box edges near the top of the
   // coordinate range cannot overflow.
   logic signed [11:0] w_bx;
   logic signed [11:0] w_by;
   logic signed [11:0] w_dx;
   logic signed [11:0] w_dy;
   logic signed [11:0] w_dx_end;
   logic signed [11:0] w_dy_end;
   logic               w_in_box;
   logic               w_active;
   logic               w_sampling;
   logic               w_cand;
   logic               w_hit;
   logic               w_ack;
   logic [7:0]         w_set_mask;
   logic [7:0]         w_clr_mask;
   logic [7:0]         w_pending_next;
   logic [2:0]         w_low_idx;

   assign w_bx     = {bullet_x[10], bullet_x};
   assign w_by     = {{2{bullet_y[9]}}, bullet_y};
   assign w_dx     = {duck_x[10], duck_x};
   assign w_dy     = {{2{duck_y[9]}}, duck_y};
   assign w_dx_end = w_dx + $signed({1'b0, DUCK_W});
   assign w_dy_end = w_dy + $signed({2'b00, DUCK_H});

   assign w_in_box = (w_bx >= w_dx) && (w_bx < w_dx_end) &&
                     (w_by >= w_dy) && (w_by < w_dy_end);
   // Negative coordinates mark an empty bullet slot.
   assign w_active   = ~bullet_x[10] & ~bullet_y[9];
   // The first edge out of reset belongs to the warm-up and is discarded.
   assign w_sampling = ~r_warm;
   // Geometric and liveness condition, before any re-arm gating.
   assign w_cand     = w_in_box & w_active & duck_alive;
   assign w_ack      = r_hit_valid & hit_ready;

`ifdef HIT_REARM_EN
   logic [7:0] r_armed;

   assign w_hit = w_sampling & w_cand & r_armed[r_slot_cnt];

   // Disarm a slot when it scores; re-arm it on any non-hitting sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_armed <= 8'hFF;
      end else if (w_sampling) begin
         r_armed[r_slot_cnt] <= ~w_cand;
      end
   end
`else
   assign w_hit = w_sampling & w_cand;
`endif

   // Per-slot set/clear masks; a set on the ack edge overrides the clear.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_mask
         assign w_set_mask[gi] = w_hit && (r_slot_cnt == 3'(gi));
         assign w_clr_mask[gi] = w_ack && (r_hit_slot == 3'(gi));
      end
   endgenerate

   assign w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;

   // Lowest pending slot gets reported first.
   always_comb begin
      w_low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_low_idx = 3'(i);
         end
      end
   end

   // Warm-up flag, round-robin slot counter and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_warm       <= 1'b1;
         r_slot_cnt   <= FIRST_SLOT;
         r_frame_done <= 1'b0;
      end else begin
         r_warm       <= 1'b0;
         r_frame_done <= w_sampling && (r_slot_cnt == 3'd7);
         if (w_sampling) begin
            r_slot_cnt <= r_slot_cnt + 3'd1;
         end
      end
   end

   // Pending-hit mask update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= 8'h00;
      end else begin
         r_pending <= w_pending_next;
      end
   end

   // Report FSM: present the lowest pending slot and hold it until accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_hit_valid <= 1'b0;
         r_hit_slot  <= 3'd0;
         r_hit_count <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_pending != 8'h00) begin
                  r_hit_slot  <= w_low_idx;
                  r_hit_valid <= 1'b1;
                  r_state     <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (hit_ready) begin
                  r_hit_valid <= 1'b0;
                  r_state     <= ST_IDLE;
                  if (r_hit_count != 8'hFF) begin
                     r_hit_count <= r_hit_count + 8'd1;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_hit_valid <= 1'b0;
            end
         endcase
      end
   end

   assign hit_valid   = r_hit_valid;
   assign hit_slot    = r_hit_slot;
   assign hit_pending = r_pending;
   assign frame_done  = r_frame_done;
   assign hit_count   = r_hit_count;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// tb_bullet_hit_detector
// Directed scenarios plus a randomized soak, all checked every cycle against
// a behavioural model of the hit detector kept in the bench.
module tb_bullet_hit_detector;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [10:0] bullet_x;
   logic signed [9:0]  bullet_y;
   logic signed [10:0] duck_x;
   logic signed [9:0]  duck_y;
   logic               duck_alive;
   logic               hit_valid;
   logic [2:0]         hit_slot;
   logic               hit_ready;
   logic [7:0]         hit_pending;
   logic               frame_done;
   logic [7:0]         hit_count;

   always #5 clk = ~clk;

   bullet_hit_detector dut (
      .clk         (clk),
      .reset       (reset),
      .bullet_y    (bullet_y),
      .bullet_x    (bullet_x),
      .duck_x      (duck_x),
      .duck_y      (duck_y),
      .duck_alive  (duck_alive),
      .hit_valid   (hit_valid),
      .hit_slot    (hit_slot),
      .hit_ready   (hit_ready),
      .hit_pending (hit_pending),
      .frame_done  (frame_done),
      .hit_count   (hit_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
   endtask

   // Behavioural model state
   bit       m_warm;
   int       m_next;        // slot to be processed at the next sampling edge
   bit [7:0] m_pend;
   bit       m_valid;
   int       m_hslot;
   int       m_count;
   bit       m_fd;
   bit [7:0] m_armed;

   function automatic int next_slot();
      return m_warm ? -1 : m_next;
   endfunction

   task automatic model_step();
      int s, bx, by, dx, dy;
      bit cand, hit;
      bit [7:0] old_pend;
      if (reset) begin
         m_warm = 1; m_next = 1; m_pend = 0; m_valid = 0; m_hslot = 0;
         m_count = 0; m_fd = 0; m_armed = 8'hFF;
         return;
      end
      s = -1; hit = 0;
      if (m_warm) begin
         m_warm = 0;
      end else begin
         s = m_next;
         m_next = (s + 1) % 8;
         bx = int'(bullet_x); by = int'(bullet_y);
         dx = int'(duck_x);   dy = int'(duck_y);
         cand = duck_alive && bx >= 0 && by >= 0 &&
                bx >= dx && bx < dx + 64 && by >= dy && by < dy + 48;
`ifdef HIT_REARM_EN
         hit = cand && m_armed[s];
         m_armed[s] = !cand;
`else
         hit = cand;
`endif
      end
      m_fd = (s == 7);
      old_pend = m_pend;
      if (m_valid && hit_ready) m_pend[m_hslot] = 0;
      if (hit) m_pend[s] = 1;
      if (m_valid) begin
         if (hit_ready) begin
            m_valid = 0;
            if (m_count < 255) m_count++;
            $display("report accepted slot=%0d count=%0d", m_hslot, m_count);
         end
      end else if (old_pend != 0) begin
         for (int i = 0; i < 8; i++) begin
            if (old_pend[i]) begin
               m_hslot = i;
               break;
            end
         end
         m_valid = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_eq("valid", int'(hit_valid), int'(m_valid));
      check_eq("pending", int'(hit_pending), int'(m_pend));
      check_eq("frame_done", int'(frame_done), int'(m_fd));
      check_eq("count", int'(hit_count), m_count);
      if (m_valid) check_eq("slot", int'(hit_slot), m_hslot);
   endtask

   task automatic set_bullet(input int x, input int y);
      bullet_x = 11'(x);
      bullet_y = 10'(y);
   endtask

   task automatic restart();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();   // warm-up edge
   endtask

   int tp2_x [8] = '{100, 163, 164, 99, 120, 100, 163, 130};
   int tp2_y [8] = '{50,  97,  97,  50, -1,  49,  98,  70};

   initial begin
      int q[$];
      int fd_ticks[$];
      int s;
      int waited;

      reset = 1'b1; duck_x = 11'sd100; duck_y = 10'sd50; duck_alive = 1'b1;
      hit_ready = 1'b0; set_bullet(120, 60);

      // Reset, warm-up, first report
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_eq("tp1_warm_pend", int'(hit_pending), 0);
      tick();
      check_eq("tp1_pend", int'(hit_pending), 8'h02);
      tick();
      check_eq("tp1_valid", int'(hit_valid), 1);
      check_eq("tp1_slot", int'(hit_slot), 1);
      hit_ready = 1'b1;
      repeat (4) tick();

      // Box edges, ready held low so the mask accumulates
      hit_ready = 1'b0;
      restart();
      for (int k = 0; k < 8; k++) begin
         s = next_slot();
         set_bullet(tp2_x[s], tp2_y[s]);
         tick();
      end
      check_eq("tp2_mask", int'(hit_pending), 8'h83);
      duck_alive = 1'b0;
      restart();
      for (int k = 0; k < 8; k++) begin
         s = next_slot();
         set_bullet(tp2_x[s], tp2_y[s]);
         tick();
      end
      check_eq("tp2_dead_mask", int'(hit_pending), 0);
      duck_alive = 1'b1;

      // Priority and backpressure
      restart();
      for (int k = 0; k < 8; k++) begin
         s = next_slot();
         if (s == 2 || s == 5 || s == 6) set_bullet(110, 60);
         else set_bullet(-5, -5);
         tick();
      end
      set_bullet(-5, -5);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_eq("tp3_hold_slot", int'(hit_slot), 2);
      end
      hit_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (hit_valid) q.push_back(int'(hit_slot));
         tick();
      end
      check_eq("tp3_nreports", q.size(), 3);
      if (q.size() == 3) begin
         check_eq("tp3_first", q[0], 2);
         check_eq("tp3_second", q[1], 5);
         check_eq("tp3_third", q[2], 6);
      end
      check_eq("tp3_count", int'(hit_count), 3);

      // Saturation: alternate in/out every 8 cycles so re-arming also works
      restart();
      for (int k = 0; k < 1400; k++) begin
         if (((k / 8) % 2) == 0) set_bullet(120, 60);
         else set_bullet(300, 300);
         tick();
      end
      check_eq("tp4_saturated", int'(hit_count), 255);

      // Reset in the middle of a report
      hit_ready = 1'b0;
      set_bullet(120, 60);
      waited = 0;
      while (!hit_valid && waited < 40) begin
         tick();
         waited++;
      end
      check_eq("tp5_wait_valid", int'(hit_valid), 1);
      reset = 1'b1;
      tick();
      check_eq("tp5_valid", int'(hit_valid), 0);
      check_eq("tp5_pend", int'(hit_pending), 0);
      check_eq("tp5_count", int'(hit_count), 0);
      reset = 1'b0;
      tick();
      check_eq("tp5_warm_pend", int'(hit_pending), 0);
      tick();
      check_eq("tp5_pend_after", int'(hit_pending), 8'h02);

      // Persistent bullet in slot 3 for four frames
      hit_ready = 1'b1;
      restart();
      for (int k = 0; k < 32; k++) begin
         if (next_slot() == 3) set_bullet(120, 60);
         else set_bullet(-5, -5);
         tick();
         if (frame_done) fd_ticks.push_back(k);
      end
      set_bullet(-5, -5);
      repeat (6) tick();
      check_eq("tp6_fd_pulses", fd_ticks.size(), 4);
      for (int i = 1; i < fd_ticks.size(); i++)
         check_eq("tp6_fd_spacing", fd_ticks[i] - fd_ticks[i-1], 8);
`ifdef HIT_REARM_EN
      check_eq("tp6_count", int'(hit_count), 1);
`else
      check_eq("tp6_count", int'(hit_count), 4);
`endif

      // Randomized soak around the box edges
      for (int k = 0; k < 2000; k++) begin
         int dx, dy;
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 63) == 0) begin
            dx = int'($urandom_range(0, 900)) - 100;
            dy = int'($urandom_range(0, 440)) - 50;
            duck_x = 11'(dx);
            duck_y = 10'(dy);
         end
         duck_alive = ($urandom_range(0, 7) != 0);
         hit_ready  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: set_bullet(-1 - int'($urandom_range(0, 50)), int'($urandom_range(0, 400)));
            1: set_bullet(int'($urandom_range(0, 1000)), int'($urandom_range(0, 500)));
            default: set_bullet(int'(duck_x) + int'($urandom_range(0, 68)) - 2,
                                int'(duck_y) + int'($urandom_range(0, 52)) - 2);
         endcase
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
